skew_loader: RTL

- Input staging stage directly upstream of the per-row delay FIFOs in the matrix multiplier.
- Host writes a DIM x DIM operand matrix one row per cycle into a local buffer.
- On start, streams it column by column: lane i carries row i, one element per cycle.
- Then drives DIM-1 flush cycles of zeros so the downstream skew FIFOs (shifted by out_en) drain completely.

---
 rtl/skew_loader_if.sv | 45 ++++
 rtl/skew_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/skew_loader_if.sv
// rtl/skew_loader_if.sv - host write / stream output bundle for skew_loader
// Carries the row-write port, the start/stall controls and the registered
// stream outputs that feed the per-row skew FIFOs.
interface skew_loader_if #(
   parameter int DIM  = 8,
   parameter int BITS = 8
);
   localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

   logic                wr_en;
   logic [RW-1:0]       wr_row;
   logic [DIM*BITS-1:0] wr_data;
   logic                start;
   logic                stall;
   logic                busy;
   logic                done;
   logic                out_en;
   logic [DIM*BITS-1:0] out_data;

   // host side: loads rows, kicks off and throttles the stream
   modport master (
      output wr_en,
      output wr_row,
      output wr_data,
      output start,
      output stall,
      input  busy,
      input  done,
      input  out_en,
      input  out_data
   );

   // loader side
   modport slave (
      input  wr_en,
      input  wr_row,
      input  wr_data,
      input  start,
      input  stall,
      output busy,
      output done,
      output out_en,
      output out_data
   );
endinterface

// File: rtl/skew_loader.sv
// rtl/skew_loader.sv - operand staging buffer that streams a matrix column by column, then flushes
// Rows are written while idle. On start the matrix leaves one column per
// cycle (lane i = row i), followed by DIM-1 zero vectors so the downstream
// skew FIFOs drain, then a one-cycle done pulse. Outputs are registered and
// computed from the transition taken at each edge, so column 0 is visible
// in the cycle right after the edge that sampled start.
module skew_loader #(
   parameter int DIM  = 8,
   parameter int BITS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   skew_loader_if.slave io
);
   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int W  = DIM * BITS;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0] LAST_COL   = CW'(DIM - 1);
   localparam logic [CW-1:0] LAST_FLUSH = CW'((DIM > 1) ? DIM - 2 : 0);

   // matrix buffer, one packed row per entry
   logic [W-1:0]  mem_q [DIM];
   logic [W-1:0]  mem_d [DIM];

   logic [1:0]    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;
   logic          out_en_q,   out_en_d;
   logic [W-1:0]  out_data_q, out_data_d;

   logic          wr_ok;
   logic          issue_col;
   logic [CW-1:0] col_idx;

   // writes are only honoured while idle and for an existing row
   assign wr_ok = io.wr_en && (state_q == S_IDLE) && (int'(io.wr_row) < DIM);

   // write-merged buffer image; a write in the start cycle is visible to column 0
   always_comb begin
      for (int r = 0; r < DIM; r++) begin
         mem_d[r] = mem_q[r];
      end
      if (wr_ok) begin
         mem_d[io.wr_row] = io.wr_data;
      end
   end

   // sequencing: decide what the next edge issues and where the FSM goes
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      out_en_d   = 1'b0;
      out_data_d = out_data_q;
      issue_col  = 1'b0;
      col_idx    = '0;

      case (state_q)
         S_IDLE: begin
            if (io.start) begin
               state_d   = S_STREAM;
               cnt_d     = '0;
               issue_col = 1'b1;
               col_idx   = '0;
            end
         end

         S_STREAM: begin
            // a stalled cycle holds everything; out_en drops so nothing shifts
            if (!io.stall) begin
               if (cnt_q == LAST_COL) begin
                  cnt_d      = '0;
                  out_data_d = '0;
                  if (DIM == 1) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d  = S_FLUSH;
                     out_en_d = 1'b1;
                  end
               end else begin
                  cnt_d     = cnt_q + CW'(1);
                  issue_col = 1'b1;
                  col_idx   = cnt_q + CW'(1);
               end
            end
         end

         S_FLUSH: begin
            if (!io.stall) begin
               out_data_d = '0;
               if (cnt_q == LAST_FLUSH) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d    = cnt_q + CW'(1);
                  out_en_d = 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d    = S_IDLE;
            out_data_d = '0;
         end

         default: begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            out_data_d = '0;
         end
      endcase

      // gather one column: lane i takes element col_idx of row i
      if (issue_col) begin
         out_en_d = 1'b1;
         for (int i = 0; i < DIM; i++) begin
            out_data_d[i*BITS +: BITS] = mem_d[i][int'(col_idx)*BITS +: BITS];
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // buffer storage, cleared by reset and retained across streams
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DIM; r++) begin
            mem_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DIM; r++) begin
            mem_q[r] <= mem_d[r];
         end
      end
   end

   // control state and registered outputs; reset aborts any stream silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         out_en_q   <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         out_en_q   <= out_en_d;
         out_data_q <= out_data_d;
      end
   end

   assign io.busy     = busy_q;
   assign io.done     = done_q;
   assign io.out_en   = out_en_q;
   assign io.out_data = out_data_q;
endmodule
